fcvt_wb_queue: RTL and testbench

Downstream result stage for the pipelined integer-to-float converter (uint32 -> fp32, fixed latency, no backpressure).
- Tracks the destination-register tag of every issued conversion alongside the converter pipe.
- Grants issue credits so results can never be lost.
- Buffers converter results in a small FIFO and presents them to the FP register-file writeback port with valid/ready.

---
 rtl/fcvt_wb_queue.sv | 157 +++++++++++++++
 tb/tb_fcvt_wb_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_wb_queue.sv
// Writeback queue for the uint32->fp32 converter: tag pipe, issue credits, result FIFO.
// Optional same-cycle bypass of an empty queue when FCVT_WBQ_BYPASS_EN is defined.
module fcvt_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [TAG_W-1:0]             issue_rd,
  output logic                         issue_ready,
  output logic                         cvt_start,
  input  logic                         cvt_valid,
  input  logic [31:0]                  cvt_y,
  output logic                         wb_valid,
  output logic [TAG_W-1:0]             wb_rd,
  output logic [31:0]                  wb_data,
  input  logic                         wb_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_n;
  logic [CNT_W-1:0] inflight_q, inflight_n;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
  logic             err_q, err_n;
  logic [TAG_W-1:0] wb_rd_q, wb_rd_n;
  logic [31:0]      wb_data_q, wb_data_n;

  logic [TAG_W-1:0] mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];

  logic [LAT-1:0]   tp_v, tp_kill;
  logic [TAG_W-1:0] tp_rd [LAT];

  logic             credit_ok, fire;
  logic             ex_v, ex_kill, ex_ok;
  logic [TAG_W-1:0] ex_rd;
  logic             bypass, push_req, full, push, pop;

  // Credits cover both queued and in-flight results, so a push can never overflow.
  always_comb begin
    credit_ok   = ((CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH);
    issue_ready = !rst && !flush && credit_ok;
    fire        = issue_valid && issue_ready;
    cvt_start   = fire;
  end

  // Exit stage; a flush in the exit cycle kills that op as well.
  always_comb begin
    ex_v    = tp_v[LAT-1];
    ex_kill = tp_kill[LAT-1] || flush;
    ex_rd   = tp_rd[LAT-1];
    ex_ok   = ex_v && !ex_kill && cvt_valid;
`ifdef FCVT_WBQ_BYPASS_EN
    bypass  = ex_ok && (count_q == '0) && wb_ready;
`else
    bypass  = 1'b0;
`endif
    push_req = ex_ok && !bypass;
    full     = (count_q == CNT_W'(DEPTH));
    push     = push_req && !full;
    pop      = (count_q != '0) && wb_ready && !flush;
  end

  // Next-state for counters, pointers, sticky error and the registered head view.
  always_comb begin
    count_n    = count_q;
    inflight_n = inflight_q + CNT_W'(fire) - CNT_W'(ex_v);
    rd_ptr_n   = rd_ptr_q;
    wr_ptr_n   = wr_ptr_q;
    err_n      = err_q || (ex_v != cvt_valid) || (push_req && full);
    wb_rd_n    = wb_rd_q;
    wb_data_n  = wb_data_q;

    if (flush) begin
      count_n  = '0;
      rd_ptr_n = wr_ptr_q;
    end else begin
      count_n  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_n = rd_ptr_q + PTR_W'(pop);
      wr_ptr_n = wr_ptr_q + PTR_W'(push);
    end

    if (count_n != '0) begin
      if (push && (wr_ptr_q == rd_ptr_n)) begin
        wb_rd_n   = ex_rd;
        wb_data_n = cvt_y;
      end else begin
        wb_rd_n   = mem_rd[rd_ptr_n];
        wb_data_n = mem_data[rd_ptr_n];
      end
    end else if (bypass) begin
      wb_rd_n   = ex_rd;
      wb_data_n = cvt_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      inflight_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      err_q      <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      tp_v       <= '0;
      tp_kill    <= '0;
    end else begin
      count_q    <= count_n;
      inflight_q <= inflight_n;
      rd_ptr_q   <= rd_ptr_n;
      wr_ptr_q   <= wr_ptr_n;
      err_q      <= err_n;
      wb_rd_q    <= wb_rd_n;
      wb_data_q  <= wb_data_n;
      tp_v[0]    <= fire;
      tp_kill[0] <= flush;
      for (int unsigned i = 1; i < LAT; i++) begin
        tp_v[i]    <= tp_v[i-1];
        tp_kill[i] <= tp_kill[i-1] || (flush && tp_v[i-1]);
      end
    end
  end

  // Payload storage needs no reset; validity lives in tp_v and count_q.
  always_ff @(posedge clk) begin
    tp_rd[0] <= issue_rd;
    for (int unsigned i = 1; i < LAT; i++) begin
      tp_rd[i] <= tp_rd[i-1];
    end
    if (!rst && push) begin
      mem_rd[wr_ptr_q]   <= ex_rd;
      mem_data[wr_ptr_q] <= cvt_y;
    end
  end

  assign count = count_q;
  assign err   = err_q;

`ifdef FCVT_WBQ_BYPASS_EN
  assign wb_valid = (count_q != '0) || bypass;
  assign wb_rd    = (count_q == '0 && bypass) ? ex_rd : wb_rd_q;
  assign wb_data  = (count_q == '0 && bypass) ? cvt_y : wb_data_q;
`else
  assign wb_valid = (count_q != '0);
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_fcvt_wb_queue.sv
// Scoreboard bench for fcvt_wb_queue with a fixed-latency converter model.
module tb_fcvt_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 4;
  localparam int unsigned TAG_W = 5;
`ifdef FCVT_WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, issue_valid, issue_ready, cvt_start, cvt_valid;
  logic [TAG_W-1:0] issue_rd, wb_rd;
  logic [31:0]      cvt_y, wb_data;
  logic             wb_valid, wb_ready, flush, err;
  logic [2:0]       count;

  int tests = 0;
  int fails = 0;
  int nfire = 0;
  int maxc  = 0;

  logic [31:0]       data_q[$];
  logic [TAG_W+31:0] exp_q[$];

  logic             inj = 1'b0;
  logic             fire_s = 1'b0;
  logic [31:0]      fire_d = '0;
  logic [LAT-1:0]   pv = '0;
  logic [31:0]      pd [LAT];

  always #5 clk = ~clk;

  fcvt_wb_queue #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .cvt_start(cvt_start), .cvt_valid(cvt_valid), .cvt_y(cvt_y),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .flush(flush), .count(count), .err(err)
  );

  // Converter model: result appears LAT cycles after the start is sampled.
  assign cvt_valid = pv[LAT-1] | inj;
  assign cvt_y     = pd[LAT-1];

  always @(negedge clk) begin
    fire_s = cvt_start;
    fire_d = '0;
    if (cvt_start) begin
      nfire++;
      if (data_q.size() != 0) fire_d = data_q.pop_front();
    end
    if (int'(count) > maxc) maxc = int'(count);
  end

  always @(posedge clk) begin
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = fire_s;
    pd[0] = fire_d;
  end

  // Monitor: every accepted writeback is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready && !flush) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got rd=%0d data=%08h, scoreboard empty", wb_rd, wb_data);
      end else begin
        logic [TAG_W+31:0] e;
        e = exp_q.pop_front();
        if ({wb_rd, wb_data} !== e) begin
          fails++;
          $display("FAIL wb_result: got rd=%0d data=%08h expected rd=%0d data=%08h",
                   wb_rd, wb_data, e[TAG_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [TAG_W-1:0] rd, input logic [31:0] d, input bit expect_out);
    issue_valid = 1'b1;
    issue_rd    = rd;
    data_q.push_back(d);
    if (expect_out) exp_q.push_back({rd, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < LAT; i++) pd[i] = '0;
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; wb_ready = 1'b0; flush = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_issue_ready", 32'(issue_ready), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", 32'(err), 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_issue_ready", 32'(issue_ready), 1);

    // Single op: issue at cycle 0, result exits at cycle LAT
    tick(); wb_ready = 1'b1;
    issue(5'd7, 32'h3F80_0000, 1'b1);
    @(negedge clk);
    chk("single_cvt_start", 32'(cvt_start), 1);
    tick(); issue_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("single_wb_valid_at_lat", 32'(wb_valid), 32'(BYP));
    chk("single_count_at_lat", 32'(count), 0);
    tick();
    @(negedge clk);
    chk("single_wb_valid_lat1", 32'(wb_valid), 32'(!BYP));
    chk("single_count_lat1", 32'(count), 32'(!BYP));
    tick();
    @(negedge clk);
    chk("single_count_drained", 32'(count), 0);
    chk("single_wb_rd_hold", 32'(wb_rd), 7);
    chk("single_wb_data_hold", wb_data, 32'h3F80_0000);

    // Credit limit with the register file stalled
    tick(); wb_ready = 1'b0;
    begin
      int n0;
      n0 = nfire;
      for (int i = 0; i < 10; i++) begin
        if (i < 4) issue(5'(i + 1), 32'h4000_0000 + 32'(i), 1'b1);
        else begin issue_valid = 1'b1; issue_rd = 5'd9; end
        tick();
      end
      issue_valid = 1'b0;
      @(negedge clk);
      chk("credit_fires", 32'(nfire - n0), 4);
    end
    chk("credit_count_full", 32'(count), 4);
    chk("credit_issue_ready_low", 32'(issue_ready), 0);
    tick(); wb_ready = 1'b1;
    @(negedge clk);
    chk("credit_ready_in_pop_cycle", 32'(issue_ready), 0);
    tick(); wb_ready = 1'b0;
    @(negedge clk);
    chk("credit_ready_after_pop", 32'(issue_ready), 1);
    chk("credit_count_after_pop", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      tick(); wb_ready = 1'b1;
    end
    tick(); wb_ready = 1'b0;
    @(negedge clk);
    chk("backpressure_drained", 32'(count), 0);

    // Flush with two queued and two in flight
    issue(5'd10, 32'h0000_00A0, 1'b0);
    tick(); issue(5'd11, 32'h0000_00B0, 1'b0);
    tick(); issue_valid = 1'b0;
    tick(); tick(); tick();
    issue(5'd12, 32'h0000_00C0, 1'b0);
    tick(); issue(5'd13, 32'h0000_00D0, 1'b0);
    tick();
    issue_valid = 1'b1; issue_rd = 5'd14; flush = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    chk("flush_count_before", 32'(count), 2);
    chk("flush_no_fire", 32'(cvt_start), 0);
    chk("flush_issue_ready", 32'(issue_ready), 0);
    tick(); flush = 1'b0; issue_valid = 1'b0; wb_ready = 1'b0;
    @(negedge clk);
    chk("flush_count_after", 32'(count), 0);
    chk("flush_wb_valid_after", 32'(wb_valid), 0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("flush_drain_ready", 32'(issue_ready), 1);
    chk("flush_drain_count", 32'(count), 0);
    chk("flush_err", 32'(err), 0);

    // Misalignment: stray converter valid with nothing outstanding
    tick(); inj = 1'b1;
    tick(); inj = 1'b0;
    @(negedge clk);
    chk("misalign_err_set", 32'(err), 1);
    chk("misalign_count", 32'(count), 0);
    chk("misalign_wb_valid", 32'(wb_valid), 0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("misalign_err_sticky", 32'(err), 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("misalign_err_cleared", 32'(err), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("max_count_le_depth", 32'(maxc <= int'(DEPTH)), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
